ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Sequences the CPU's single RAM port and shares it between two requesters: the instruction-fetch path and the load/store path (LB/SB from bus control). Each access runs a fixed address/data cycle sequence that drives RAM port 1 (`ram_en`, `ram_we`, `ram_out_en`). The fetch path and bus control use a req/gnt/done handshake and never touch RAM enables directly. Sits between bus control, fetch logic and RAM.

## Interface
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `STARVE_LIMIT`, 4, consecutive load/store grants allowed while fetch waits (only with fairness macro)

- `clk` in 1 — the single clock; everything on rising edge
- `rst` in 1 — synchronous, active-high reset
- `fetch_req` in 1 — fetch wants a read
- `fetch_addr` in ADDR_WIDTH — fetch address, stable while `fetch_req` high and no grant
- `fetch_gnt` out 1 — one-cycle pulse; fetch request accepted
- `fetch_done` out 1 — one-cycle pulse; `fetch_rdata` valid
- `fetch_rdata` out DATA_WIDTH — read data, held until next fetch completion
- `ls_req` in 1 — load/store wants an access
- `ls_we` in 1 — 1 = store, 0 = load
- `ls_addr` in ADDR_WIDTH, `ls_wdata` in DATA_WIDTH — held stable until grant
- `ls_gnt` out 1, `ls_done` out 1 — as fetch; `ls_done` pulses for stores too
- `ls_rdata` out DATA_WIDTH — load data, held until next load completion
- `ram_en`, `ram_we`, `ram_out_en` out 1 — RAM port 1 controls
- `ram_addr` out ADDR_WIDTH, `ram_wdata` out DATA_WIDTH — RAM address/write data
- `ram_rdata` in DATA_WIDTH — RAM read data, valid during DATA state

## Operation
- FSM states: IDLE, ADDR, DATA. All outputs registered.
- IDLE: arbitrate on sampled reqs. Winner latched (id, addr, we, wdata). Next: ADDR. `*_gnt` pulses, `ram_en`=1, `ram_addr`=latched addr, `ram_we`=latched we, `ram_wdata`=latched wdata.
- ADDR, store: next IDLE. `ls_done` pulses in that IDLE cycle. `ram_en`/`ram_we` return to 0.
- ADDR, read: next DATA. `ram_out_en`=1, `ram_en`=0.
- DATA: capture `ram_rdata` into winner's rdata register. Next IDLE. `*_done` pulses, `ram_out_en`=0.
- Arbitration happens only in IDLE. Reqs seen in ADDR/DATA are ignored, not lost, because the requester holds them.
- Priority: `ls_req` beats `fetch_req`. A sole requester always wins.
- Handshake: requester holds req plus payload until it sees gnt. Requester drops req in the cycle after gnt, unless issuing a new request. A req still high in the next IDLE is a new access.
- Unused outputs are 0. `ram_addr`/`ram_wdata` hold their last value when `ram_en`=0.

## Timing
- Reset: state IDLE. All gnt/done/ram_* controls 0. `ram_addr`, `ram_wdata`, `*_rdata` = 0. Starvation counter 0.
- Read: req sampled at edge E0 → gnt/`ram_en` in cycle 1 → `ram_out_en` in cycle 2 → done/rdata in cycle 3. Next arbitration at the end of cycle 3.
- Store: req at E0 → gnt/`ram_en`/`ram_we` in cycle 1 → `ls_done` in cycle 2, with arbitration in that same cycle.
- Peak throughput: one read per 3 cycles, one store per 2 cycles.
- Both reqs at the same edge: ls is granted. Fetch keeps waiting with req high.
- Reset mid-access: the FSM aborts to IDLE the next cycle. No done pulse. A store in ADDR may or may not have been written. Requesters reissue.
- gnt and done never pulse for both requesters in the same cycle.

## Configuration
- `RAM_ARB_FAIRNESS_EN` defined: a counter increments on each ls grant made while `fetch_req` is high. The counter clears on any fetch grant, or on any ls grant with `fetch_req` low. When it equals `STARVE_LIMIT`, fetch wins the next IDLE arbitration even with `ls_req` high. Counter width is $clog2(STARVE_LIMIT+1).
- Not defined: strict ls priority. No counter logic.

## Structure
- Shared defines/package: FSM state encodings `ARB_IDLE`/`ARB_ADDR`/`ARB_DATA`, requester ids `ARB_ID_FETCH`/`ARB_ID_LS`.
- One sub-module: `arb_starve_counter` (counter plus force-fetch output), instantiated only under `RAM_ARB_FAIRNESS_EN`.

## Test plan
- Reset, then fetch read at addr 0x10 with RAM returning 0xA5 → `fetch_gnt` in cycle 1, `ram_out_en` in cycle 2, `fetch_done`=1 with `fetch_rdata`=0xA5 in cycle 3.
- Store 0x3C to 0x20 → `ram_en`=`ram_we`=1 with `ram_addr`=0x20 and `ram_wdata`=0x3C for exactly one cycle, then `ls_done`; a later load from 0x20 returns 0x3C.
- `fetch_req` and `ls_req` (load 0x05) rise together → `ls_gnt` first; fetch is granted in the IDLE after `ls_done`.
- Fairness on, `STARVE_LIMIT`=4, `ls_req` held continuously with back-to-back stores, fetch pending → 4 ls grants, then `fetch_gnt`; with the macro off, fetch is never granted.
- `rst` asserted during DATA of a load → the next cycle has state IDLE, all outputs 0, and no `ls_done`; a reissued load completes normally.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port 1 arbiter: FSM state encodings and requester ids.
package ram_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    localparam logic ARB_ID_FETCH = 1'b0;
    localparam logic ARB_ID_LS    = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Fetch starvation guard: counts ls grants made while fetch waits and forces a fetch win at the limit.
// Only built when RAM_ARB_FAIRNESS_EN is defined.
`ifdef RAM_ARB_FAIRNESS_EN
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ls_grant_i,
    input  logic fetch_grant_i,
    input  logic fetch_req_i,
    output logic force_fetch_c
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // An ls grant with nobody waiting resets the streak.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch_grant_i) begin
            cnt_d = '0;
        end else if (ls_grant_i) begin
            cnt_d = fetch_req_i ? cnt_q + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch_c = (cnt_q == CW'(STARVE_LIMIT));

endmodule
`endif

// File: rtl/ram_port_arbiter.sv
// Sequences RAM port 1 (IDLE/ADDR/DATA) and shares it between fetch and load/store.
// Define RAM_ARB_FAIRNESS_EN to bound how long ls can starve a waiting fetch.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic                  ram_out_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic [1:0]            state_q,       state_d;
    logic                  id_q,          id_d;
    logic                  fetch_gnt_q,   fetch_gnt_d;
    logic                  fetch_done_q,  fetch_done_d;
    logic [DATA_WIDTH-1:0] fetch_rdata_q, fetch_rdata_d;
    logic                  ls_gnt_q,      ls_gnt_d;
    logic                  ls_done_q,     ls_done_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q,    ls_rdata_d;
    logic                  ram_en_q,      ram_en_d;
    logic                  ram_we_q,      ram_we_d;
    logic                  ram_out_en_q,  ram_out_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q,   ram_wdata_d;

    logic idle;
    logic force_fetch;
    logic ls_win;
    logic fetch_win;

    assign idle      = (state_q == ARB_IDLE);
    assign ls_win    = idle && ls_req && !(force_fetch && fetch_req);
    assign fetch_win = idle && fetch_req && !ls_win;

`ifdef RAM_ARB_FAIRNESS_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clk),
        .rst           (rst),
        .ls_grant_i    (ls_win),
        .fetch_grant_i (fetch_win),
        .fetch_req_i   (fetch_req),
        .force_fetch_c (force_fetch)
    );
`else
    // Strict ls priority; the limit only matters when the guard is built.
    assign force_fetch = (STARVE_LIMIT == 0) && 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        fetch_gnt_d   = 1'b0;
        fetch_done_d  = 1'b0;
        fetch_rdata_d = fetch_rdata_q;
        ls_gnt_d      = 1'b0;
        ls_done_d     = 1'b0;
        ls_rdata_d    = ls_rdata_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_out_en_d  = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (ls_win) begin
                    state_d     = ARB_ADDR;
                    id_d        = ARB_ID_LS;
                    ls_gnt_d    = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_we_d    = ls_we;
                    ram_addr_d  = ls_addr;
                    ram_wdata_d = ls_wdata;
                end else if (fetch_win) begin
                    state_d     = ARB_ADDR;
                    id_d        = ARB_ID_FETCH;
                    fetch_gnt_d = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_addr_d  = fetch_addr;
                end
            end
            // ram_we_q still holds the latched direction of the access in flight.
            ARB_ADDR: begin
                if (ram_we_q) begin
                    state_d   = ARB_IDLE;
                    ls_done_d = 1'b1;
                end else begin
                    state_d      = ARB_DATA;
                    ram_out_en_d = 1'b1;
                end
            end
            ARB_DATA: begin
                state_d = ARB_IDLE;
                if (id_q == ARB_ID_LS) begin
                    ls_rdata_d = ram_rdata;
                    ls_done_d  = 1'b1;
                end else begin
                    fetch_rdata_d = ram_rdata;
                    fetch_done_d  = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            id_q          <= ARB_ID_FETCH;
            fetch_gnt_q   <= 1'b0;
            fetch_done_q  <= 1'b0;
            fetch_rdata_q <= '0;
            ls_gnt_q      <= 1'b0;
            ls_done_q     <= 1'b0;
            ls_rdata_q    <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_out_en_q  <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            fetch_gnt_q   <= fetch_gnt_d;
            fetch_done_q  <= fetch_done_d;
            fetch_rdata_q <= fetch_rdata_d;
            ls_gnt_q      <= ls_gnt_d;
            ls_done_q     <= ls_done_d;
            ls_rdata_q    <= ls_rdata_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_out_en_q  <= ram_out_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign fetch_gnt   = fetch_gnt_q;
    assign fetch_done  = fetch_done_q;
    assign fetch_rdata = fetch_rdata_q;
    assign ls_gnt      = ls_gnt_q;
    assign ls_done     = ls_done_q;
    assign ls_rdata    = ls_rdata_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_out_en  = ram_out_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level memory/latency model.
module tb_ram_port_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt, fetch_done;
    logic [DW-1:0] fetch_rdata;
    logic          ls_req, ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt, ls_done;
    logic [DW-1:0] ls_rdata;
    logic          ram_en, ram_we, ram_out_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_done  (fetch_done),
        .fetch_rdata (fetch_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_gnt      (ls_gnt),
        .ls_done     (ls_done),
        .ls_rdata    (ls_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_out_en  (ram_out_en),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // RAM behind port 1, with a bench-side preload path.
    logic [DW-1:0] ram_mem [256];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_en) ram_mem[pl_addr] <= pl_data;
        else if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram_out_en ? ram_mem[ram_addr] : '0;

    // Reference memory contents as the requesters see them, in grant order.
    logic [DW-1:0] ref_mem [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fetch_req = 1'b0;
        ls_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        pl_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d = (i == 'h10) ? 8'hA5 : DW'($urandom);
            pl_addr = AW'(i);
            pl_data = d;
            ref_mem[i] = d;
            tick();
        end
        pl_en = 1'b0;
        checks++;
        if ({fetch_gnt, fetch_done, ls_gnt, ls_done, ram_en, ram_we, ram_out_en} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {fetch_gnt, fetch_done, ls_gnt, ls_done, ram_en, ram_we, ram_out_en});
        end
        checks++;
        if ({ram_addr, ram_wdata, fetch_rdata, ls_rdata} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=00000000", {ram_addr, ram_wdata, fetch_rdata, ls_rdata});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({fetch_gnt, ls_gnt, ram_en, ram_out_en} !== 4'b0) begin
            failures++;
            $display("FAIL idle_no_req got=%b want=0000", {fetch_gnt, ls_gnt, ram_en, ram_out_en});
        end
    endtask

    task automatic test_fetch_read();
        fetch_addr = 8'h10;
        fetch_req = 1'b1;
        tick();
        checks++;
        if ({fetch_gnt, ls_gnt, ram_en, ram_we, ram_out_en, ram_addr} !== {5'b10100, 8'h10}) begin
            failures++;
            $display("FAIL fetch_c1 got=%b/%h want=10100/10",
                     {fetch_gnt, ls_gnt, ram_en, ram_we, ram_out_en}, ram_addr);
        end
        fetch_req = 1'b0;
        tick();
        checks++;
        if ({fetch_gnt, ram_en, ram_out_en, fetch_done} !== 4'b0010) begin
            failures++;
            $display("FAIL fetch_c2 got=%b want=0010", {fetch_gnt, ram_en, ram_out_en, fetch_done});
        end
        tick();
        checks++;
        if ({fetch_done, ls_done, ram_out_en, fetch_rdata} !== {3'b100, 8'hA5}) begin
            failures++;
            $display("FAIL fetch_c3 got=%b/%h want=100/a5", {fetch_done, ls_done, ram_out_en}, fetch_rdata);
        end
        tick();
        checks++;
        if ({fetch_done, fetch_rdata} !== {1'b0, 8'hA5}) begin
            failures++;
            $display("FAIL fetch_hold got=%b/%h want=0/a5", fetch_done, fetch_rdata);
        end
    endtask

    task automatic test_store_load();
        ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 8'h3C;
        ls_req = 1'b1;
        tick();
        ref_mem['h20] = 8'h3C;
        checks++;
        if ({ls_gnt, fetch_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {4'b1011, 8'h20, 8'h3C}) begin
            failures++;
            $display("FAIL store_c1 got=%b/%h/%h want=1011/20/3c",
                     {ls_gnt, fetch_gnt, ram_en, ram_we}, ram_addr, ram_wdata);
        end
        ls_req = 1'b0;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_out_en, ls_done, ls_gnt} !== 5'b00010) begin
            failures++;
            $display("FAIL store_c2 got=%b want=00010", {ram_en, ram_we, ram_out_en, ls_done, ls_gnt});
        end
        ls_we = 1'b0; ls_wdata = 8'h00;
        ls_req = 1'b1;
        tick();
        checks++;
        if ({ls_gnt, ls_done, ram_en, ram_we} !== 4'b1010) begin
            failures++;
            $display("FAIL store_then_load_gnt got=%b want=1010", {ls_gnt, ls_done, ram_en, ram_we});
        end
        ls_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({ls_done, ls_rdata} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL load_back got=%b/%h want=1/3c", ls_done, ls_rdata);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp_f;
        fetch_addr = 8'h10; fetch_req = 1'b1;
        ls_we = 1'b0; ls_addr = 8'h05; ls_req = 1'b1;
        tick();
        checks++;
        if ({ls_gnt, fetch_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL collide_gnt got=%b want=10", {ls_gnt, fetch_gnt});
        end
        ls_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({ls_done, fetch_gnt, ls_rdata} !== {2'b10, ref_mem['h05]}) begin
            failures++;
            $display("FAIL collide_ls_done got=%b/%h want=10/%h", {ls_done, fetch_gnt}, ls_rdata, ref_mem['h05]);
        end
        tick();
        checks++;
        if ({fetch_gnt, ls_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL collide_fetch_gnt got=%b want=10", {fetch_gnt, ls_gnt});
        end
        exp_f = ref_mem['h10];
        fetch_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({fetch_done, fetch_rdata} !== {1'b1, exp_f}) begin
            failures++;
            $display("FAIL collide_fetch_done got=%b/%h want=1/%h", fetch_done, fetch_rdata, exp_f);
        end
    endtask

    task automatic test_fairness();
        int  ls_grants = 0;
        bit  fgnt = 1'b0;
        int  want_grants;
        logic [DW-1:0] exp_f;
        apply_reset();
        fetch_addr = 8'h33; fetch_req = 1'b1;
        ls_we = 1'b1; ls_addr = AW'($urandom); ls_wdata = DW'($urandom); ls_req = 1'b1;
        for (int c = 0; c < 40 && !fgnt; c++) begin
            tick();
            if (ls_gnt) begin
                ref_mem[ls_addr] = ls_wdata;
                ls_grants++;
                ls_addr = AW'($urandom);
                ls_wdata = DW'($urandom);
            end
            if (fetch_gnt) fgnt = 1'b1;
        end
`ifdef RAM_ARB_FAIRNESS_EN
        want_grants = int'(LIMIT);
        checks++;
        if (fgnt !== 1'b1) begin
            failures++;
            $display("FAIL fair_fetch_gnt got=%0d want=1", fgnt);
        end
`else
        want_grants = 20;
        checks++;
        if (fgnt !== 1'b0) begin
            failures++;
            $display("FAIL strict_no_fetch got=%0d want=0", fgnt);
        end
`endif
        checks++;
        if (ls_grants != want_grants) begin
            failures++;
            $display("FAIL starve_ls_grants got=%0d want=%0d", ls_grants, want_grants);
        end
        ls_req = 1'b0;
        for (int c = 0; c < 6 && !fgnt; c++) begin
            tick();
            if (fetch_gnt) fgnt = 1'b1;
        end
        checks++;
        if (!fgnt) begin
            failures++;
            $display("FAIL starve_fetch_timeout got=0 want=1");
        end
        exp_f = ref_mem['h33];
        fetch_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({fetch_done, fetch_rdata} !== {1'b1, exp_f}) begin
            failures++;
            $display("FAIL starve_fetch_data got=%b/%h want=1/%h", fetch_done, fetch_rdata, exp_f);
        end
    endtask

    task automatic test_reset_mid();
        ls_we = 1'b0; ls_addr = 8'h44; ls_req = 1'b1;
        tick();
        ls_req = 1'b0;
        tick();
        checks++;
        if (ram_out_en !== 1'b1) begin
            failures++;
            $display("FAIL midrst_data_phase got=%b want=1", ram_out_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({fetch_gnt, fetch_done, ls_gnt, ls_done, ram_en, ram_we, ram_out_en,
             ram_addr, ram_wdata, fetch_rdata, ls_rdata} !== 39'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b/%h want=0",
                     {fetch_gnt, fetch_done, ls_gnt, ls_done, ram_en, ram_we, ram_out_en},
                     {ram_addr, ram_wdata, fetch_rdata, ls_rdata});
        end
        ls_req = 1'b1;
        tick();
        checks++;
        if ({ls_gnt, ls_done} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_reissue_gnt got=%b want=10", {ls_gnt, ls_done});
        end
        ls_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({ls_done, ls_rdata} !== {1'b1, ref_mem['h44]}) begin
            failures++;
            $display("FAIL midrst_reissue_data got=%b/%h want=1/%h", ls_done, ls_rdata, ref_mem['h44]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] fq_data [$];
        int            fq_cyc  [$];
        logic [DW-1:0] lq_data [$];
        int            lq_cyc  [$];
        bit            lq_we   [$];
        bit f_fin = 1'b0;
        bit l_fin = 1'b0;
        fork
            begin : fetch_side
                bit got;
                for (int n = 0; n < 25; n++) begin
                    fetch_addr = AW'($urandom);
                    fetch_req = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 40 && !got; t++) begin
                        tick();
                        if (fetch_gnt) got = 1'b1;
                    end
                    checks++;
                    if (!got) begin
                        failures++;
                        $display("FAIL rand_fetch_gnt_timeout got=0 want=1");
                    end else begin
                        fq_data.push_back(ref_mem[fetch_addr]);
                        fq_cyc.push_back(cyc + 2);
                    end
                    fetch_req = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                end
                f_fin = 1'b1;
            end
            begin : ls_side
                bit got;
                for (int n = 0; n < 25; n++) begin
                    ls_we = 1'($urandom_range(0, 1));
                    ls_addr = AW'($urandom);
                    ls_wdata = DW'($urandom);
                    ls_req = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 40 && !got; t++) begin
                        tick();
                        if (ls_gnt) got = 1'b1;
                    end
                    checks++;
                    if (!got) begin
                        failures++;
                        $display("FAIL rand_ls_gnt_timeout got=0 want=1");
                    end else if (ls_we) begin
                        ref_mem[ls_addr] = ls_wdata;
                        lq_we.push_back(1'b1); lq_data.push_back(ls_wdata); lq_cyc.push_back(cyc + 1);
                    end else begin
                        lq_we.push_back(1'b0); lq_data.push_back(ref_mem[ls_addr]); lq_cyc.push_back(cyc + 2);
                    end
                    ls_req = 1'b0;
                    repeat ($urandom_range(2, 4)) tick();
                end
                l_fin = 1'b1;
            end
            begin : monitor
                int ec;
                logic [DW-1:0] ed;
                bit ew;
                for (int t = 0; t < 4000; t++) begin
                    tick();
                    checks++;
                    if ((fetch_gnt && ls_gnt) || (fetch_done && ls_done)) begin
                        failures++;
                        $display("FAIL rand_exclusive got=%b want=no pair", {fetch_gnt, ls_gnt, fetch_done, ls_done});
                    end
                    if (fetch_done) begin
                        checks++;
                        if (fq_cyc.size() == 0) begin
                            failures++;
                            $display("FAIL rand_fetch_spurious_done got=1 want=0");
                        end else begin
                            ec = fq_cyc.pop_front(); ed = fq_data.pop_front();
                            if (cyc != ec || fetch_rdata !== ed) begin
                                failures++;
                                $display("FAIL rand_fetch_done got=cyc%0d/%h want=cyc%0d/%h", cyc, fetch_rdata, ec, ed);
                            end
                        end
                    end
                    if (ls_done) begin
                        checks++;
                        if (lq_cyc.size() == 0) begin
                            failures++;
                            $display("FAIL rand_ls_spurious_done got=1 want=0");
                        end else begin
                            ec = lq_cyc.pop_front(); ed = lq_data.pop_front(); ew = lq_we.pop_front();
                            if (cyc != ec || (!ew && ls_rdata !== ed)) begin
                                failures++;
                                $display("FAIL rand_ls_done got=cyc%0d/%h want=cyc%0d/%h we=%0d", cyc, ls_rdata, ec, ed, ew);
                            end
                        end
                    end
                    if (fq_cyc.size() != 0 && fq_cyc[0] < cyc) begin
                        checks++; failures++;
                        $display("FAIL rand_fetch_missing_done got=none want=cyc%0d", fq_cyc[0]);
                        void'(fq_cyc.pop_front()); void'(fq_data.pop_front());
                    end
                    if (lq_cyc.size() != 0 && lq_cyc[0] < cyc) begin
                        checks++; failures++;
                        $display("FAIL rand_ls_missing_done got=none want=cyc%0d", lq_cyc[0]);
                        void'(lq_cyc.pop_front()); void'(lq_data.pop_front()); void'(lq_we.pop_front());
                    end
                    if (f_fin && l_fin && fq_cyc.size() == 0 && lq_cyc.size() == 0) break;
                end
                checks++;
                if (!(f_fin && l_fin) || fq_cyc.size() != 0 || lq_cyc.size() != 0) begin
                    failures++;
                    $display("FAIL rand_drain got=%0d/%0d want=0/0", fq_cyc.size(), lq_cyc.size());
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store_load();
        test_collision();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
